// File: rtl/ldpc_pkg.sv
// Shared LDPC message-format constants used by both sign-magnitude and
// two's-complement conversion paths.
package ldpc_pkg;

    localparam int DATA_WIDTH_DEF = 6;

    // The sign bit is the MSB, just above the magnitude field.
    function automatic int sign_idx(input int w);
        return w;
    endfunction

    function automatic int max_pos(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int max_neg_mag(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/s_to_t_sat.sv
// Single-lane sign-magnitude to two's-complement converter.
// Magnitudes outside the representable range clip and raise sat_o.
module s_to_t_sat
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH:0]   sm_i,
    output logic [DATA_WIDTH-1:0] tc_o,
    output logic                  sat_o
);

    localparam int                  SIGN = sign_idx(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MAXP = DATA_WIDTH'(max_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MAXN = DATA_WIDTH'(max_neg_mag(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    logic                  sign;
    logic [DATA_WIDTH-1:0] mag;

    assign sign = sm_i[SIGN];
    assign mag  = sm_i[DATA_WIDTH-1:0];

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        tc_o  = '0;
        sat_o = 1'b0;
        if (!sign) begin
            if (mag > MAXP) begin
                tc_o  = MAXP;
                sat_o = 1'b1;
            end else begin
                tc_o = mag;
            end
        end else begin
            // MAXN's bit pattern is also the most negative code; negative zero negates to 0.
            if (mag > MAXN) begin
                tc_o  = MAXN;
                sat_o = 1'b1;
            end else begin
                tc_o = ~mag + ONE;
            end
        end
    end

endmodule

// File: rtl/s_to_t_packer.sv
// Streams sign-magnitude messages in, converts each with saturation and packs
// DEGREE of them into one registered two's-complement frame word.
module s_to_t_packer
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEGREE     = 4,
    localparam int CNT_W     = $clog2(DEGREE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEGREE*DATA_WIDTH-1:0] out_data,
    output logic [DEGREE-1:0]            out_sat
);

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [DEGREE*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DEGREE-1:0]            flag_q, flag_d;
    logic                         out_valid_q, out_valid_d;
    logic [DEGREE*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DEGREE-1:0]            out_sat_q, out_sat_d;

    logic [DATA_WIDTH-1:0] lane_tc;
    logic                  lane_sat;
    logic                  last_lane;
    logic                  accept;

    s_to_t_sat #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
        .sm_i  (in_data),
        .tc_o  (lane_tc),
        .sat_o (lane_sat)
    );

    assign last_lane = (cnt_q == CNT_W'(DEGREE - 1));
    // Only the completing beat waits on the output; it may pass through as the old frame leaves.
    assign in_ready  = !rst && !(last_lane && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        flag_d      = flag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            buf_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = lane_tc;
            flag_d[cnt_q]                                = lane_sat;
            if (last_lane) begin
                out_data_d  = buf_d;
                out_sat_d   = flag_d;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            buf_q       <= '0;
            flag_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
